// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch requester, data requester and shared memory port.
// slave is the arbiter's view; master is the surrounding requesters/memory.
interface mem_port_arbiter_if;
    logic        i_read;
    logic [31:0] i_address;
    logic        i_resp;
    logic [31:0] i_rdata;

    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic        d_resp;
    logic [31:0] d_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_read, i_address,
        output i_resp, i_rdata,
        input  d_read, d_write, d_byte_enable, d_address, d_wdata,
        output d_resp, d_rdata,
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport master (
        output i_read, i_address,
        input  i_resp, i_rdata,
        output d_read, d_write, d_byte_enable, d_address, d_wdata,
        input  d_resp, d_rdata,
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// The granted command is registered and frozen until the memory completes.
module mem_port_arbiter #(
    parameter logic D_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_e;

    state_e      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        d_req;
    logic        i_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            // Last grant starts as the opposite side so D_FIRST wins the first tie.
            last_d_q <= ~D_FIRST;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        d_req    = bus.d_read | bus.d_write;
        i_req    = bus.i_read;

        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    // A simultaneous read and write is taken as a write.
                    rd_d     = bus.d_read & ~bus.d_write;
                    wr_d     = bus.d_write;
                    be_d     = bus.d_write ? bus.d_byte_enable : '1;
                    addr_d   = bus.d_address;
                    wdata_d  = bus.d_wdata;
                end else if (i_req) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    rd_d     = 1'b1;
                    wr_d     = 1'b0;
                    be_d     = '1;
                    addr_d   = bus.i_address;
                    wdata_d  = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    assign bus.mem_read        = rd_q;
    assign bus.mem_write       = wr_q;
    assign bus.mem_byte_enable = be_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;

    assign bus.i_resp  = (state_q == SERVE_I) & bus.mem_resp;
    assign bus.d_resp  = (state_q == SERVE_D) & bus.mem_resp;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then random traffic
// checked against a transaction-level round-robin reference model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.D_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.i_read        = 1'b0;
        bus.i_address     = '0;
        bus.d_read        = 1'b0;
        bus.d_write       = 1'b0;
        bus.d_byte_enable = '0;
        bus.d_address     = '0;
        bus.d_wdata       = '0;
        bus.mem_resp      = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 of cycle 0 with reset released.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Random-phase reference model state
    bit          m_busy, m_own_d, m_last_d;
    logic        e_rd, e_wr;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    bit          i_pend, d_pend, d_rd, d_wr;
    logic [31:0] i_a, d_a, d_wd;
    logic [3:0]  d_be;
    logic [1:0]  op;
    bit          mb;
    int unsigned lat;
    bit          exp_i, exp_d;

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Instruction fetch, memory answers 2 cycles after the strobe
        do_reset();
        check_eq("rst_mem_read",  32'(bus.mem_read), 32'd0);
        check_eq("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check_eq("rst_mem_addr",  bus.mem_address, 32'd0);
        check_eq("rst_mem_be",    32'(bus.mem_byte_enable), 32'd0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
        bus.i_read    = 1'b1;
        bus.i_address = 32'h60;
        step();
        check_eq("if_c1_read", 32'(bus.mem_read), 32'd1);
        check_eq("if_c1_addr", bus.mem_address, 32'h60);
        check_eq("if_c1_be",   32'(bus.mem_byte_enable), 32'hf);
        check_eq("if_c1_resp", 32'(bus.i_resp), 32'd0);
        step();
        check_eq("if_c2_resp", 32'(bus.i_resp), 32'd0);
        step();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h13;
        #1;
        check_eq("if_c3_resp",  32'(bus.i_resp), 32'd1);
        check_eq("if_c3_rdata", bus.i_rdata, 32'h13);
        check_eq("if_c3_dresp", 32'(bus.d_resp), 32'd0);
        step();
        bus.mem_resp = 1'b0;
        bus.i_read   = 1'b0;
        check_eq("if_c4_read", 32'(bus.mem_read), 32'd0);
        check_eq("if_c4_resp", 32'(bus.i_resp), 32'd0);

        // Data write with mid-transaction address change, then a data read
        do_reset();
        bus.d_write       = 1'b1;
        bus.d_address     = 32'h100;
        bus.d_wdata       = 32'hDEADBEEF;
        bus.d_byte_enable = 4'b0011;
        step();
        for (int k = 0; k < 3; k++) begin
            check_eq("wr_write", 32'(bus.mem_write), 32'd1);
            check_eq("wr_read",  32'(bus.mem_read), 32'd0);
            check_eq("wr_addr",  bus.mem_address, 32'h100);
            check_eq("wr_wdata", bus.mem_wdata, 32'hDEADBEEF);
            check_eq("wr_be",    32'(bus.mem_byte_enable), 32'h3);
            check_eq("wr_noresp", 32'(bus.d_resp), 32'd0);
            if (k == 1) bus.d_address = 32'h200;
            step();
        end
        bus.mem_resp = 1'b1;
        #1;
        check_eq("wr_dresp",     32'(bus.d_resp), 32'd1);
        check_eq("wr_iresp",     32'(bus.i_resp), 32'd0);
        check_eq("wr_addr_hold", bus.mem_address, 32'h100);
        step();
        bus.mem_resp = 1'b0;
        bus.d_write  = 1'b0;
        check_eq("wr_after_write", 32'(bus.mem_write), 32'd0);
        check_eq("wr_after_resp",  32'(bus.d_resp), 32'd0);
        bus.d_read    = 1'b1;
        bus.d_address = 32'h104;
        step();
        check_eq("rd_read",  32'(bus.mem_read), 32'd1);
        check_eq("rd_write", 32'(bus.mem_write), 32'd0);
        check_eq("rd_be",    32'(bus.mem_byte_enable), 32'hf);
        check_eq("rd_addr",  bus.mem_address, 32'h104);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h55;
        #1;
        check_eq("rd_dresp", 32'(bus.d_resp), 32'd1);
        check_eq("rd_rdata", bus.d_rdata, 32'h55);
        step();
        idle_inputs();

        // Read and write together count as a write
        do_reset();
        bus.d_read        = 1'b1;
        bus.d_write       = 1'b1;
        bus.d_byte_enable = 4'b0101;
        bus.d_address     = 32'h40;
        step();
        check_eq("rw_write", 32'(bus.mem_write), 32'd1);
        check_eq("rw_read",  32'(bus.mem_read), 32'd0);
        check_eq("rw_be",    32'(bus.mem_byte_enable), 32'h5);
        bus.mem_resp = 1'b1;
        step();
        idle_inputs();

        // Asynchronous reset during a data write abandons it
        do_reset();
        bus.d_write   = 1'b1;
        bus.d_address = 32'h80;
        step();
        check_eq("ar_write_pre", 32'(bus.mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_write_now", 32'(bus.mem_write), 32'd0);
        check_eq("ar_addr_now",  bus.mem_address, 32'd0);
        bus.d_write = 1'b0;
        step();
        rst = 1'b0;
        step();
        bus.mem_resp = 1'b1;
        #1;
        check_eq("ar_stray_dresp", 32'(bus.d_resp), 32'd0);
        check_eq("ar_stray_iresp", 32'(bus.i_resp), 32'd0);
        step();
        idle_inputs();

        // Both requesting continuously: D, I, D, I with an idle gap between
        do_reset();
        bus.i_read    = 1'b1;
        bus.i_address = 32'h10;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h20;
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.mem_resp = bus.mem_read | bus.mem_write;
            #1;
            if (c % 2 == 1) begin
                exp_d = (((c - 1) / 2) % 2) == 0;
                check_eq("rr_dresp", 32'(bus.d_resp), 32'(exp_d));
                check_eq("rr_iresp", 32'(bus.i_resp), 32'(!exp_d));
                check_eq("rr_addr",  bus.mem_address, exp_d ? 32'h20 : 32'h10);
            end else begin
                check_eq("rr_gap", 32'(bus.mem_read), 32'd0);
            end
        end
        step();
        idle_inputs();

        // Random traffic against the reference model
        do_reset();
        m_busy   = 1'b0;
        m_own_d  = 1'b0;
        m_last_d = 1'b0;   // data wins the first tie when D_FIRST=1
        i_pend   = 1'b0;
        d_pend   = 1'b0;
        mb       = 1'b0;
        lat      = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!i_pend && ($urandom % 2 == 0)) begin
                i_pend = 1'b1;
                i_a    = $urandom;
            end
            if (!d_pend && ($urandom % 2 == 0)) begin
                d_pend = 1'b1;
                op     = 2'($urandom_range(1, 3));
                d_rd   = op[0];
                d_wr   = op[1];
                d_be   = 4'($urandom);
                d_a    = $urandom;
                d_wd   = $urandom;
            end
            bus.i_read        = i_pend;
            bus.i_address     = i_pend ? i_a : $urandom;
            bus.d_read        = d_pend & d_rd;
            bus.d_write       = d_pend & d_wr;
            bus.d_byte_enable = d_be;
            bus.d_address     = d_pend ? d_a : $urandom;
            bus.d_wdata       = d_wd;
            if (m_busy && ($urandom % 4 == 0)) begin
                if (m_own_d) bus.d_address = $urandom;
                else         bus.i_address = $urandom;
            end

            bus.mem_resp  = 1'b0;
            bus.mem_rdata = $urandom;
            if ((bus.mem_read | bus.mem_write) && !mb) begin
                mb  = 1'b1;
                lat = $urandom_range(0, 3);
            end
            if (mb) begin
                if (lat == 0) begin
                    bus.mem_resp = 1'b1;
                    mb = 1'b0;
                end else begin
                    lat--;
                end
            end else if ($urandom % 8 == 0) begin
                bus.mem_resp = 1'b1;
            end
            #1;

            exp_i = m_busy && !m_own_d && bus.mem_resp;
            exp_d = m_busy &&  m_own_d && bus.mem_resp;
            check_eq("rnd_read",  32'(bus.mem_read),  32'(m_busy ? e_rd : 1'b0));
            check_eq("rnd_write", 32'(bus.mem_write), 32'(m_busy ? e_wr : 1'b0));
            check_eq("rnd_iresp", 32'(bus.i_resp), 32'(exp_i));
            check_eq("rnd_dresp", 32'(bus.d_resp), 32'(exp_d));
            if (m_busy) begin
                check_eq("rnd_addr",  bus.mem_address, e_addr);
                check_eq("rnd_be",    32'(bus.mem_byte_enable), 32'(e_be));
                check_eq("rnd_wdata", bus.mem_wdata, e_wd);
            end
            if (exp_i) check_eq("rnd_irdata", bus.i_rdata, bus.mem_rdata);
            if (exp_d) check_eq("rnd_drdata", bus.d_rdata, bus.mem_rdata);

            if (m_busy) begin
                if (bus.mem_resp) begin
                    m_busy = 1'b0;
                    if (m_own_d) d_pend = 1'b0;
                    else         i_pend = 1'b0;
                end
            end else if (i_pend || d_pend) begin
                m_own_d  = d_pend && (!i_pend || !m_last_d);
                m_last_d = m_own_d;
                m_busy   = 1'b1;
                if (m_own_d) begin
                    e_rd   = d_rd && !d_wr;
                    e_wr   = d_wr;
                    e_be   = d_wr ? d_be : 4'hf;
                    e_addr = d_a;
                    e_wd   = d_wd;
                end else begin
                    e_rd   = 1'b1;
                    e_wr   = 1'b0;
                    e_be   = 4'hf;
                    e_addr = i_a;
                    e_wd   = 32'd0;
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
